// File: rtl/data_mem_responder_if.sv
// Load/store port between the core's memory stage (master) and the data memory (slave).
// Request and response each use their own valid/ready handshake.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_write, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised RV32I data memory: one outstanding request, WAIT_CYCLES wait states,
// byte-lane stores, sign/zero-extended loads, and an error response for bad accesses.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        fire, commit;

  logic [31:0] mem_q [DEPTH_WORDS];

  // Access view: live request when committing straight from IDLE, latched copy otherwise.
  logic [31:0]      a_addr, a_wdata, a_word, a_shift, a_load, a_wlanes;
  logic             a_write, a_uns, a_err;
  logic [1:0]       a_size;
  logic [3:0]       a_be;
  logic [IDX_W-1:0] a_idx;

  assign bus.req_ready = (state_q == S_IDLE) && !rst;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign fire          = bus.req_valid && bus.req_ready;

  always_comb begin
    if (state_q == S_IDLE) begin
      a_addr  = bus.req_addr;
      a_wdata = bus.req_wdata;
      a_write = bus.req_write;
      a_size  = bus.req_size;
      a_uns   = bus.req_unsigned;
    end else begin
      a_addr  = addr_q;
      a_wdata = wdata_q;
      a_write = write_q;
      a_size  = size_q;
      a_uns   = uns_q;
    end
  end

  always_comb begin
    a_idx   = a_addr[IDX_W+1:2];
    a_word  = mem_q[a_idx];
    a_shift = a_word >> {a_addr[1:0], 3'b000};
    unique case (a_size)
      2'b00: begin
        a_err    = 1'b0;
        a_be     = 4'b0001 << a_addr[1:0];
        a_wlanes = {4{a_wdata[7:0]}};
        a_load   = a_uns ? {24'd0, a_shift[7:0]} : {{24{a_shift[7]}}, a_shift[7:0]};
      end
      2'b01: begin
        a_err    = a_addr[0];
        a_be     = a_addr[1] ? 4'b1100 : 4'b0011;
        a_wlanes = {2{a_wdata[15:0]}};
        a_load   = a_uns ? {16'd0, a_shift[15:0]} : {{16{a_shift[15]}}, a_shift[15:0]};
      end
      2'b10: begin
        a_err    = |a_addr[1:0];
        a_be     = 4'b1111;
        a_wlanes = a_wdata;
        a_load   = a_word;
      end
      default: begin
        a_err    = 1'b1;
        a_be     = 4'b0000;
        a_wlanes = a_wdata;
        a_load   = a_word;
      end
    endcase
    if ({2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS)) a_err = 1'b1;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fire) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          write_d = bus.req_write;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      rdata_d = (a_err || a_write) ? 32'd0 : a_load;
      err_d   = a_err;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the array is deliberately not reset; rst only suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && commit && a_write && !a_err) begin
      for (int b = 0; b < 4; b++) begin
        if (a_be[b]) mem_q[a_idx][8*b +: 8] <= a_wlanes[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a byte-addressed reference memory.
module tb_data_mem_responder;
  localparam int DEPTH = 256;
  localparam int W     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] mb [4*DEPTH];

  // Reference: RV32I load/store semantics on a flat byte array.
  function automatic void model(input logic [31:0] addr, input logic wr, input logic [1:0] sz,
                                input logic un, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
    int unsigned n;
    logic [31:0] v;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || ((addr % n) != 0) || ((addr / 4) >= DEPTH);
    rd  = 32'd0;
    if (err) return;
    if (wr) begin
      for (int i = 0; i < int'(n); i++) mb[int'(addr) + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < int'(n); i++) v = v | (32'(mb[int'(addr) + i]) << (8*i));
      if (!un && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      rd = v;
    end
  endfunction

  task automatic send(input logic [31:0] a, input logic w, input logic [1:0] s, input logic u,
                      input logic [31:0] d, output bit ok);
    int g = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;  bus.req_addr = a;  bus.req_write = w;
    bus.req_size  = s;     bus.req_unsigned = u;  bus.req_wdata = d;
    while (!bus.req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    ok = bus.req_ready;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.rsp_valid) lat = -1;
  endtask

  task automatic take_rsp(input int hold, output logic [31:0] rd, output logic err);
    rd  = bus.rsp_rdata;
    err = bus.rsp_err;
    repeat (hold) @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic xact(input logic [31:0] a, input logic w, input logic [1:0] s, input logic u,
                      input logic [31:0] d, input int hold,
                      output logic [31:0] rd, output logic err, output int lat);
    bit ok;
    send(a, w, s, u, d, ok);
    wait_rsp(lat);
    if (!ok) lat = -1;
    take_rsp(hold, rd, err);
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0;  bus.req_addr = '0;  bus.req_write = 1'b0;  bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;  bus.req_wdata = '0;  bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got ready=%b valid=%b rdata=%h err=%b, want 0 0 00000000 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got ready=%b valid=%b, want 1 0", bus.req_ready, bus.rsp_valid);
    end
  endtask

  // Runs a table of accesses; each has a hand-derived expected value and the model's value.
  task automatic run_table(input string name, input int cnt, input logic [31:0] ta[8],
                           input logic tw[8], input logic [1:0] ts[8], input logic tu[8],
                           input logic [31:0] td[8], input logic [31:0] twant[8], input logic terr[8]);
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int lat;
    for (int i = 0; i < cnt; i++) begin
      model(ta[i], tw[i], ts[i], tu[i], td[i], exp_rd, exp_err);
      xact(ta[i], tw[i], ts[i], tu[i], td[i], 0, rd, err, lat);
      total++;
      if (rd !== twant[i] || rd !== exp_rd || err !== terr[i] || err !== exp_err || lat != W) begin
        bad++;
        $display("FAIL %s[%0d]: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                 name, i, rd, err, lat, twant[i], terr[i], W);
      end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] ta[8] = '{8, 8, 0, 0, 0, 0, 0, 0};
    logic        tw[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    logic [1:0]  ts[8] = '{2, 2, 0, 0, 0, 0, 0, 0};
    logic        tu[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] td[8] = '{32'h3FE, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] tr[8] = '{0, 32'h3FE, 0, 0, 0, 0, 0, 0};
    logic        te[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_table("store_load", 2, ta, tw, ts, tu, td, tr, te);
  endtask

  task automatic test_extensions();
    logic [31:0] ta[8] = '{8, 8, 8, 8, 9, 0, 0, 0};
    logic        tw[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    logic [1:0]  ts[8] = '{0, 0, 1, 1, 0, 0, 0, 0};
    logic        tu[8] = '{0, 1, 0, 1, 0, 0, 0, 0};
    logic [31:0] td[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] tr[8] = '{32'hFFFF_FFFE, 32'hFE, 32'h3FE, 32'h3FE, 32'h3, 0, 0, 0};
    logic        te[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_table("extend", 5, ta, tw, ts, tu, td, tr, te);
  endtask

  task automatic test_partial();
    logic [31:0] ta[8] = '{12, 13, 12, 14, 12, 0, 0, 0};
    logic        tw[8] = '{1, 1, 0, 1, 0, 0, 0, 0};
    logic [1:0]  ts[8] = '{2, 0, 2, 1, 2, 0, 0, 0};
    logic        tu[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] td[8] = '{32'h1234_5678, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0, 0, 0, 0};
    logic [31:0] tr[8] = '{0, 0, 32'h1234_FF78, 0, 32'hFFFF_FF78, 0, 0, 0};
    logic        te[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_table("partial", 5, ta, tw, ts, tu, td, tr, te);
  endtask

  task automatic test_errors();
    logic [31:0] ta[8] = '{9, 10, 8, 4*DEPTH, 8, 3, 0, 0};
    logic        tw[8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    logic [1:0]  ts[8] = '{1, 2, 2, 2, 3, 0, 0, 0};
    logic        tu[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] td[8] = '{0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0};
    logic [31:0] tr[8] = '{0, 0, 32'h3FE, 0, 0, 0, 0, 0};
    logic        te[8] = '{1, 1, 0, 1, 1, 0, 0, 0};
    run_table("errors", 5, ta, tw, ts, tu, td, tr, te);
  endtask

  task automatic test_backpressure();
    logic [31:0] r0, rd, exp_rd;
    logic e0, err, exp_err;
    bit ok;
    int lat;
    model(32'd8, 1'b0, 2'd2, 1'b0, 32'd0, exp_rd, exp_err);
    send(32'd8, 1'b0, 2'd2, 1'b0, 32'd0, ok);
    wait_rsp(lat);
    r0 = bus.rsp_rdata;
    e0 = bus.rsp_err;
    total++;
    if (!ok || lat != W || r0 !== exp_rd || e0 !== exp_err) begin
      bad++;
      $display("FAIL bp_first: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
               r0, e0, lat, exp_rd, exp_err, W);
    end
    bus.req_valid = 1'b1;  bus.req_addr = 32'd12;  bus.req_write = 1'b1;
    bus.req_size  = 2'd2;  bus.req_wdata = 32'h5555_5555;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp_rd || bus.rsp_err !== exp_err || bus.req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h err=%b ready=%b, want 1 %h %b 0",
                 k, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready, exp_rd, exp_err);
      end
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got valid=%b ready=%b, want 0 1", bus.rsp_valid, bus.req_ready);
    end
    model(32'd12, 1'b0, 2'd2, 1'b0, 32'd0, exp_rd, exp_err);
    xact(32'd12, 1'b0, 2'd2, 1'b0, 32'd0, 0, rd, err, lat);
    total++;
    if (rd !== exp_rd || err !== exp_err || lat != W) begin
      bad++;
      $display("FAIL bp_ignored_store: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
               rd, err, lat, exp_rd, exp_err, W);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    bit ok;
    int lat;
    model(32'd16, 1'b1, 2'd2, 1'b0, 32'h1357_9BDF, exp_rd, exp_err);
    xact(32'd16, 1'b1, 2'd2, 1'b0, 32'h1357_9BDF, 0, rd, err, lat);
    // Store to abort: reset lands on the commit edge itself, so the model is not updated.
    send(32'd16, 1'b1, 2'd2, 1'b0, 32'hAAAA_AAAA, ok);
    repeat (W - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_commit: got valid=%b ready=%b, want 0 0", bus.rsp_valid, bus.req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_commit_after: got valid=%b ready=%b, want 0 1", bus.rsp_valid, bus.req_ready);
    end
    model(32'd16, 1'b0, 2'd2, 1'b0, 32'd0, exp_rd, exp_err);
    xact(32'd16, 1'b0, 2'd2, 1'b0, 32'd0, 0, rd, err, lat);
    total++;
    if (rd !== 32'h1357_9BDF || rd !== exp_rd || err !== 1'b0 || lat != W) begin
      bad++;
      $display("FAIL rst_commit_mem: got rdata=%h err=%b lat=%0d, want rdata=13579bdf err=0 lat=%0d",
               rd, err, lat, W);
    end
    // Response dropped by reset while in RESP.
    send(32'd16, 1'b0, 2'd2, 1'b0, 32'd0, ok);
    wait_rsp(lat);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (lat != W || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_resp: got lat=%0d valid=%b rdata=%h err=%b, want lat=%0d 0 00000000 0",
               lat, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, W);
    end
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_resp_ready: got ready=%b, want 1", bus.req_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd, exp_rd;
    logic [1:0] s;
    logic w, u, err, exp_err;
    int lat, hold;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      model(32'(4*i), 1'b1, 2'd2, 1'b0, d, exp_rd, exp_err);
      xact(32'(4*i), 1'b1, 2'd2, 1'b0, d, 0, rd, err, lat);
    end
    for (int i = 0; i < 80; i++) begin
      a    = ($urandom_range(0, 9) == 0) ? 32'(4*DEPTH + $urandom_range(0, 15)) : 32'($urandom_range(0, 63));
      w    = 1'($urandom_range(0, 1));
      s    = 2'($urandom_range(0, 3));
      u    = 1'($urandom_range(0, 1));
      d    = $urandom;
      hold = $urandom_range(0, 2);
      model(a, w, s, u, d, exp_rd, exp_err);
      xact(a, w, s, u, d, hold, rd, err, lat);
      total++;
      if (rd !== exp_rd || err !== exp_err || lat != W) begin
        bad++;
        $display("FAIL random[%0d] a=%h w=%b s=%0d u=%b: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                 i, a, w, s, u, rd, err, lat, exp_rd, exp_err, W);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_extensions();
    test_partial();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-organised data memory that answers load/store requests issued by the RV32I core's memory stage. It sits on the core's data port as the responding end of a valid/ready request/response handshake. It applies configurable wait states, byte-lane stores, and sign/zero-extended loads for all RV32I load/store widths. It reports misaligned or out-of-range accesses with an error flag instead of touching memory.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; word index = req_addr[31:2]
- WAIT_CYCLES, 1: wait states between accept and response; 0 allowed, max 15
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE and not in reset
- req_addr  in  32  byte address
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: zero-extend (lbu/lhu) instead of sign-extend
- req_wdata  in  32  store data; the low bits are used for byte and half stores
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator accepts response
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  access rejected

## Operation
- States: IDLE, WAIT, RESP.
- Request fires on the edge where req_valid && req_ready. The responder latches addr, write, size, unsigned, and wdata.
  - If WAIT_CYCLES = 0, the FSM goes to RESP.
  - Otherwise it goes to WAIT with the counter set to WAIT_CYCLES-1.
- WAIT: the counter decrements each cycle. On the edge leaving WAIT with counter = 0, the FSM commits the access and goes to RESP.
- Commit edge: the access is performed on the edge entering RESP. This is the same edge as accept when WAIT_CYCLES = 0.
- Error conditions (any one sets rsp_err = 1, blocks the memory write, and forces rsp_rdata = 0):
  - size = 11
  - half access with addr[0] = 1
  - word access with addr[1:0] ≠ 00
  - addr[31:2] ≥ DEPTH_WORDS
- Store lane selection:
  - byte: wdata[7:0] goes to lane addr[1:0]
  - half: wdata[15:0] goes to lanes {addr[1],0} and {addr[1],1}
  - word: all four lanes
  - Untouched lanes keep their contents. rsp_rdata = 0.
- Load: the selected byte or half is right-justified and then sign-extended (unsigned = 0) or zero-extended (unsigned = 1). Word loads are returned as-is.
- RESP: rsp_valid, rsp_rdata, and rsp_err are held stable until rsp_ready. On the edge where rsp_valid && rsp_ready, the FSM goes to IDLE.
- One outstanding request at a time. No request is accepted in WAIT or RESP.
- Reset clears FSM state, the counter, and the outputs. Memory contents are not cleared by rst.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, counter 0. req_ready = 0 while rst = 1, and 1 in the first cycle after rst is deasserted.
- Latency: request accepted at edge N gives rsp_valid = 1 starting in the cycle after edge N+WAIT_CYCLES. With WAIT_CYCLES = 1, rsp_valid rises one cycle after the accept cycle plus one.
- Throughput: the next accept is possible no earlier than the cycle after the response handshake edge. Back-to-back minimum period = WAIT_CYCLES + 2 cycles.
- Response backpressure: rsp_ready low holds RESP indefinitely with outputs frozen. Memory is unaffected; the store is already committed.
- req_valid may drop without penalty while req_ready = 0. Inputs are sampled only on the accept edge.
- Reset mid-operation:
  - If rst is high on the commit edge, no write occurs.
  - If rst is high in RESP, the response is dropped.
  - In both cases the FSM is in IDLE after the edge.
- Store followed by load to the same address returns the new data. The write is committed before the store's response.

## Test plan
- Store then load words: sw 0x000003FE at addr 8, then lw at addr 8 → rsp_rdata 0x000003FE, rsp_err 0. rsp_valid rises exactly WAIT_CYCLES+1 cycles after accept.
- Load extensions from word 0x000003FE at addr 8:
  - lb → 0xFFFFFFFE
  - lbu → 0x000000FE
  - lh → 0x000003FE
  - lhu → 0x000003FE
  - lb at addr 9 → 0x00000003
- Partial stores: word 12 = 0x12345678.
  - sb 0xFFFFFFFF at addr 13, then lw 12 → 0x1234FF78.
  - sh 0xFFFFFFFF at addr 14, then lw 12 → 0xFFFFFF78.
- Errors:
  - lh at addr 9 → rsp_err 1, rdata 0.
  - sw at addr 10 → rsp_err 1, and word 8 is unchanged.
  - lw at addr 4*DEPTH_WORDS → rsp_err 1.
- Backpressure: hold rsp_ready low for 3 cycles after rsp_valid → outputs stable, req_ready stays 0, a new req_valid is ignored. The handshake completes on the first edge with rsp_ready = 1.
- Reset during WAIT of an sw 0xAAAAAAAA at addr 16 (WAIT_CYCLES = 3) → after reset, lw 16 returns the prior contents. rsp_valid is 0 through and after reset, and req_ready = 1 one cycle after rst falls.
